// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser plus four-state bounce filter for one raw input
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter bit          ACTIVE_LOW_IN   = 1'b0
) (
  input  logic CLK,
  input  logic Reset_N,
  input  logic Button_In,
  output logic Level_Out,
  output logic Busy,
  output logic Bounce_Detected
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           sync;
  logic                 s;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 level_nxt;
  logic                 busy_nxt;
  logic                 bounce_nxt;
  logic                 cnt_done;

  // Reset value makes the polarity-corrected sample read as deasserted.
  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      sync <= {2{ACTIVE_LOW_IN}};
    end else begin
      sync <= {sync[0], Button_In};
    end
  end

  assign s        = sync[1] ^ ACTIVE_LOW_IN;
  assign cnt_done = (cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      state           <= IDLE_LOW;
      cnt             <= '0;
      Level_Out       <= 1'b0;
      Busy            <= 1'b0;
      Bounce_Detected <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      Level_Out       <= level_nxt;
      Busy            <= busy_nxt;
      Bounce_Detected <= bounce_nxt;
    end
  end

  // Abort is checked before terminal count so a glitch in the last wait cycle still cancels.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_LOW:  state_nxt = s ? WAIT_HIGH : IDLE_LOW;
      WAIT_HIGH: begin
        if (!s)            state_nxt = IDLE_LOW;
        else if (cnt_done) state_nxt = IDLE_HIGH;
        else               state_nxt = WAIT_HIGH;
      end
      IDLE_HIGH: state_nxt = s ? IDLE_HIGH : WAIT_LOW;
      WAIT_LOW:  begin
        if (s)             state_nxt = IDLE_HIGH;
        else if (cnt_done) state_nxt = IDLE_LOW;
        else               state_nxt = WAIT_LOW;
      end
      default:   state_nxt = IDLE_LOW;
    endcase
  end

  always_comb begin
    cnt_nxt    = cnt;
    level_nxt  = Level_Out;
    busy_nxt   = Busy;
    bounce_nxt = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (s) begin
          cnt_nxt  = '0;
          busy_nxt = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          busy_nxt   = 1'b0;
          bounce_nxt = 1'b1;
        end else if (cnt_done) begin
          level_nxt = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          cnt_nxt  = '0;
          busy_nxt = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          busy_nxt   = 1'b0;
          bounce_nxt = 1'b1;
        end else if (cnt_done) begin
          level_nxt = 1'b0;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        level_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed bench for button_debouncer, active-high and active-low instances
module tb_button_debouncer;

  localparam int unsigned DC = 4;

  logic CLK = 1'b0;
  logic Reset_N;
  logic button_in;
  logic level_out;
  logic busy;
  logic bounce_detected;
  logic button_in_al;
  logic level_out_al;
  logic busy_al;
  logic bounce_detected_al;

  int checks = 0;
  int errors = 0;
  int bounce_cnt = 0;
  int bounce_cnt_al = 0;

  always #5 CLK = ~CLK;

  button_debouncer #(.DEBOUNCE_CYCLES(DC), .CNT_WIDTH(16), .ACTIVE_LOW_IN(1'b0)) dut (
    .CLK(CLK), .Reset_N(Reset_N), .Button_In(button_in),
    .Level_Out(level_out), .Busy(busy), .Bounce_Detected(bounce_detected)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DC), .CNT_WIDTH(16), .ACTIVE_LOW_IN(1'b1)) dut_al (
    .CLK(CLK), .Reset_N(Reset_N), .Button_In(button_in_al),
    .Level_Out(level_out_al), .Busy(busy_al), .Bounce_Detected(bounce_detected_al)
  );

  // Advance n clocks, sampling on the falling edge and tallying bounce pulses.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bounce_detected === 1'b1) bounce_cnt++;
      if (bounce_detected_al === 1'b1) bounce_cnt_al++;
    end
  endtask

  task automatic test_reset();
    Reset_N = 1'b0;
    cyc(3);
    checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL reset_level got %b exp 0", level_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (level_out_al !== 1'b0) begin errors++; $display("FAIL reset_level_al got %b exp 0", level_out_al); end
    Reset_N = 1'b1;
    bounce_cnt = 0;
    bounce_cnt_al = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      checks++; if (level_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_low cycle %0d got level %b busy %b exp 0 0", i, level_out, busy); end
    end
    checks++; if (bounce_cnt !== 0) begin errors++; $display("FAIL idle_bounce got %0d exp 0", bounce_cnt); end
    checks++; if (level_out_al !== 1'b0 || bounce_cnt_al !== 0) begin errors++; $display("FAIL idle_al got level %b bounces %0d exp 0 0", level_out_al, bounce_cnt_al); end
  endtask

  task automatic test_rise();
    button_in = 1'b1;
    cyc(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rise_busy_early got %b exp 0", busy); end
    cyc(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rise_busy_k2 got %b exp 1", busy); end
    cyc(3);
    checks++; if (level_out !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rise_k5 got level %b busy %b exp 0 1", level_out, busy); end
    cyc(1);
    checks++; if (level_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rise_k6 got level %b busy %b exp 1 0", level_out, busy); end
  endtask

  task automatic test_fall_bounce();
    bounce_cnt = 0;
    button_in = 1'b0;
    cyc(3);
    button_in = 1'b1;
    cyc(10);
    checks++; if (bounce_cnt !== 1) begin errors++; $display("FAIL fall_bounce_pulses got %0d exp 1", bounce_cnt); end
    checks++; if (level_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fall_bounce_hold got level %b busy %b exp 1 0", level_out, busy); end
    button_in = 1'b0;
    cyc(6);
    checks++; if (level_out !== 1'b1) begin errors++; $display("FAIL fall_k5 got %b exp 1", level_out); end
    cyc(1);
    checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL fall_k6 got %b exp 0", level_out); end
  endtask

  task automatic test_rise_bounce();
    bounce_cnt = 0;
    button_in = 1'b1;
    cyc(2);
    button_in = 1'b0;
    cyc(1);
    button_in = 1'b1;
    cyc(6);
    checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL rise_bounce_k5 got %b exp 0", level_out); end
    checks++; if (bounce_cnt !== 1) begin errors++; $display("FAIL rise_bounce_pulses got %0d exp 1", bounce_cnt); end
    cyc(1);
    checks++; if (level_out !== 1'b1) begin errors++; $display("FAIL rise_bounce_k6 got %b exp 1", level_out); end
  endtask

  task automatic test_last_cycle_glitch();
    button_in = 1'b0;
    cyc(10);
    checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL glitch_setup got %b exp 0", level_out); end
    bounce_cnt = 0;
    button_in = 1'b1;
    cyc(4);
    button_in = 1'b0;
    cyc(1);
    button_in = 1'b1;
    cyc(6);
    checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL glitch_no_rise got %b exp 0", level_out); end
    checks++; if (bounce_cnt !== 1) begin errors++; $display("FAIL glitch_pulses got %0d exp 1", bounce_cnt); end
    cyc(1);
    checks++; if (level_out !== 1'b1) begin errors++; $display("FAIL glitch_requalify got %b exp 1", level_out); end
  endtask

  task automatic test_reset_mid_wait();
    button_in = 1'b0;
    cyc(10);
    button_in = 1'b1;
    cyc(5);
    checks++; if (busy !== 1'b1 || level_out !== 1'b0) begin errors++; $display("FAIL mid_wait_setup got busy %b level %b exp 1 0", busy, level_out); end
    #2 Reset_N = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || level_out !== 1'b0 || bounce_detected !== 1'b0) begin errors++; $display("FAIL async_reset got busy %b level %b bounce %b exp 0 0 0", busy, level_out, bounce_detected); end
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy got %b exp 0", busy); end
    Reset_N = 1'b1;
    cyc(6);
    checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL post_reset_k5 got %b exp 0", level_out); end
    cyc(1);
    checks++; if (level_out !== 1'b1) begin errors++; $display("FAIL post_reset_k6 got %b exp 1", level_out); end
  endtask

  task automatic test_active_low();
    int n;
    checks++; if (level_out_al !== 1'b0) begin errors++; $display("FAIL al_idle got %b exp 0", level_out_al); end
    button_in_al = 1'b0;
    cyc(6);
    checks++; if (level_out_al !== 1'b0) begin errors++; $display("FAIL al_k5 got %b exp 0", level_out_al); end
    cyc(1);
    checks++; if (level_out_al !== 1'b1) begin errors++; $display("FAIL al_k6 got %b exp 1", level_out_al); end
    bounce_cnt_al = 0;
    repeat (12) begin
      button_in_al = 1'b1;
      n = $urandom_range(3, 1);
      for (int i = 0; i < n; i++) begin
        cyc(1);
        checks++; if (level_out_al !== 1'b1) begin errors++; $display("FAIL al_burst_hi got %b exp 1", level_out_al); end
      end
      button_in_al = 1'b0;
      n = $urandom_range(3, 1);
      for (int i = 0; i < n; i++) begin
        cyc(1);
        checks++; if (level_out_al !== 1'b1) begin errors++; $display("FAIL al_burst_lo got %b exp 1", level_out_al); end
      end
    end
    cyc(10);
    checks++; if (level_out_al !== 1'b1 || busy_al !== 1'b0) begin errors++; $display("FAIL al_after_burst got level %b busy %b exp 1 0", level_out_al, busy_al); end
    checks++; if (bounce_cnt_al !== 12) begin errors++; $display("FAIL al_burst_pulses got %0d exp 12", bounce_cnt_al); end
  endtask

  initial begin
    Reset_N = 1'b0;
    button_in = 1'b0;
    button_in_al = 1'b1;
    @(negedge CLK);
    test_reset();
    test_rise();
    test_fall_bounce();
    test_rise_bounce();
    test_last_cycle_glitch();
    test_reset_mid_wait();
    test_active_low();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
